// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with start/load/run/done handshake and relative branching
module pc_sequencer #(
  parameter int D = 12,
  parameter logic [D-1:0] P1_START = D'(0),
  parameter logic [D-1:0] P2_START = D'(256),
  parameter logic [D-1:0] P3_START = D'(512),
  parameter int CW = 16
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic [1:0]    prog_sel,
  input  logic          stall,
  input  logic          branch_en,
  input  logic          branch_taken,
  input  logic [D-1:0]  target,
  input  logic          halt,
  output logic [D-1:0]  prog_ctr,
  output logic          running,
  output logic          Done,
  output logic [CW-1:0] cycle_cnt
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [D-1:0] pc_q, pc_d, start_addr;
  logic [1:0] sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic running_q, running_d, done_q, done_d;
  // next-state: stall beats halt beats branch beats +1; the offset add wraps modulo 2^D
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    sel_d = sel_q;
    cnt_d = cnt_q;
    start_addr = sel_q == 2'd1 ? P2_START : sel_q == 2'd2 ? P3_START : P1_START;
    case (state_q)
      IDLE: begin
        sel_d = Start ? prog_sel : sel_q;
        state_d = Start ? LOAD : IDLE;
      end
      LOAD: begin
        pc_d = start_addr;
        cnt_d = '0;
        state_d = RUN;
      end
      RUN: if (!stall) begin
        state_d = halt ? DONE : RUN;
        pc_d = halt ? pc_q : (branch_en && branch_taken) ? pc_q + target : pc_q + D'(1);
        cnt_d = (halt || &cnt_q) ? cnt_q : cnt_q + CW'(1);
      end
      DONE: state_d = Start ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
    running_d = state_d == LOAD || state_d == RUN;
    done_d = state_d == DONE;
  end
  // state and registered outputs; reset clears everything immediately
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      pc_q <= '0;
      sel_q <= '0;
      cnt_q <= '0;
      running_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
      running_q <= running_d;
      done_q <= done_d;
    end
  end
  assign prog_ctr = pc_q;
  assign cycle_cnt = cnt_q;
  assign running = running_q;
  assign Done = done_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed stimulus with a behavioural model checked every cycle
module tb_pc_sequencer;
  logic Clk, Reset_n, Start, stall, branch_en, branch_taken, halt;
  logic [1:0] prog_sel;
  logic [11:0] target, prog_ctr;
  logic running, Done;
  logic [15:0] cycle_cnt;
  int n_chk = 0, n_fail = 0;
  bit chk_en = 0;
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_DONE = 3;
  int m_ph, m_pc, m_cnt, m_sel;

  pc_sequencer dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .prog_sel(prog_sel), .stall(stall),
    .branch_en(branch_en), .branch_taken(branch_taken), .target(target), .halt(halt),
    .prog_ctr(prog_ctr), .running(running), .Done(Done), .cycle_cnt(cycle_cnt)
  );

  initial Clk = 0;
  always #5 Clk = ~Clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = M_IDLE; m_pc = 0; m_cnt = 0; m_sel = 0;
  endtask

  task automatic model_step();
    int off;
    case (m_ph)
      M_IDLE: if (Start) begin m_sel = int'(prog_sel); m_ph = M_LOAD; end
      M_LOAD: begin
        m_pc = m_sel == 1 ? 256 : m_sel == 2 ? 512 : 0;
        m_cnt = 0;
        m_ph = M_RUN;
      end
      M_RUN: if (!stall) begin
        if (halt) m_ph = M_DONE;
        else begin
          off = (branch_en && branch_taken) ? (int'(target) >= 2048 ? int'(target) - 4096 : int'(target)) : 1;
          m_pc = (m_pc + off + 4096) % 4096;
          if (m_cnt < 65535) m_cnt++;
        end
      end
      default: if (!Start) m_ph = M_IDLE;
    endcase
  endtask

  always @(negedge Clk) if (chk_en) begin
    check("pc", 32'(prog_ctr), m_pc);
    check("cnt", 32'(cycle_cnt), m_cnt);
    check("running", 32'(running), 32'(m_ph == M_LOAD || m_ph == M_RUN));
    check("done", 32'(Done), 32'(m_ph == M_DONE));
  end

  task automatic cyc(input logic s, input logic [1:0] ps, input logic stl, input logic be,
                     input logic bt, input logic [11:0] tg, input logic h);
    Start = s; prog_sel = ps; stall = stl; branch_en = be; branch_taken = bt; target = tg; halt = h;
    @(posedge Clk);
    model_step();
    @(negedge Clk);
  endtask

  task automatic adv(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 12'd0, 0);
  endtask

  initial begin
    Reset_n = 0; Start = 0; prog_sel = 0; stall = 0; branch_en = 0; branch_taken = 0; target = 0; halt = 0;
    model_reset();
    repeat (2) @(negedge Clk);
    check("rst_pc", 32'(prog_ctr), 0);
    check("rst_running", 32'(running), 0);
    check("rst_done", 32'(Done), 0);
    Reset_n = 1;
    chk_en = 1;
    cyc(1, 1, 0, 0, 0, 12'd0, 0);
    check("load_running", 32'(running), 1);
    cyc(1, 1, 0, 0, 0, 12'd0, 0);
    check("first_run_pc", 32'(prog_ctr), 256);
    repeat (3) cyc(1, 0, 0, 0, 0, 12'd0, 0);
    check("inc_pc", 32'(prog_ctr), 259);
    cyc(0, 0, 0, 1, 1, 12'hFC5, 0);
    check("to200", 32'(prog_ctr), 200);
    cyc(0, 0, 0, 1, 1, 12'hF97, 0);
    check("back_branch", 32'(prog_ctr), 95);
    check("back_cnt", 32'(cycle_cnt), 5);
    cyc(0, 0, 0, 1, 1, 12'h069, 0);
    cyc(0, 0, 0, 1, 0, 12'hF97, 0);
    check("not_taken", 32'(prog_ctr), 201);
    cyc(0, 0, 0, 1, 1, 12'd3889, 0);
    check("to4090", 32'(prog_ctr), 4090);
    cyc(0, 0, 0, 1, 1, 12'd9, 0);
    check("fwd_wrap", 32'(prog_ctr), 3);
    cyc(0, 0, 0, 1, 1, 12'hFFC, 0);
    adv(1);
    check("inc_wrap", 32'(prog_ctr), 0);
    cyc(0, 0, 0, 1, 1, 12'd0, 0);
    check("self_loop_pc", 32'(prog_ctr), 0);
    check("self_loop_cnt", 32'(cycle_cnt), 12);
    cyc(1, 0, 1, 1, 1, 12'd14, 1);
    check("stall_cnt", 32'(cycle_cnt), 12);
    check("stall_running", 32'(running), 1);
    cyc(1, 0, 0, 1, 1, 12'd14, 1);
    check("halt_pc", 32'(prog_ctr), 0);
    check("halt_done", 32'(Done), 1);
    repeat (3) cyc(1, 0, 0, 0, 0, 12'd0, 0);
    check("done_hold", 32'(Done), 1);
    cyc(0, 0, 0, 0, 0, 12'd0, 0);
    check("done_drop", 32'(Done), 0);
    cyc(1, 2, 0, 0, 0, 12'd0, 0);
    cyc(0, 2, 0, 0, 0, 12'd0, 0);
    check("p3_start", 32'(prog_ctr), 512);
    adv(1);
    cyc(0, 0, 0, 0, 0, 12'd0, 1);
    cyc(0, 0, 0, 0, 0, 12'd0, 0);
    check("idle_pc_hold", 32'(prog_ctr), 513);
    cyc(1, 3, 0, 0, 0, 12'd0, 0);
    cyc(0, 3, 0, 0, 0, 12'd0, 0);
    check("sel3_pc", 32'(prog_ctr), 0);
    adv(65540);
    check("sat_cnt", 32'(cycle_cnt), 65535);
    check("sat_pc", 32'(prog_ctr), 4);
    cyc(0, 0, 0, 0, 0, 12'd0, 1);
    cyc(0, 0, 0, 0, 0, 12'd0, 0);
    cyc(1, 1, 0, 0, 0, 12'd0, 0);
    cyc(0, 1, 0, 0, 0, 12'd0, 0);
    check("reload_cnt", 32'(cycle_cnt), 0);
    repeat (6) cyc(0, 0, 0, 1, 1, 12'd0, 0);
    adv(44);
    check("pre_rst_pc", 32'(prog_ctr), 300);
    check("pre_rst_cnt", 32'(cycle_cnt), 50);
    #2 Reset_n = 0;
    chk_en = 0;
    model_reset();
    #1;
    check("arst_pc", 32'(prog_ctr), 0);
    check("arst_cnt", 32'(cycle_cnt), 0);
    check("arst_running", 32'(running), 0);
    repeat (2) @(negedge Clk);
    Reset_n = 1;
    chk_en = 1;
    adv(2);
    check("post_rst_running", 32'(running), 0);
    check("post_rst_pc", 32'(prog_ctr), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
